// File: rtl/b16_loader.sv
// b16 serial download controller and SRAM bus arbiter.
// Optional byte echo on txd when B16_LOADER_ECHO_EN is defined.
module b16_loader #(
    parameter int BIT_CLKS = 87
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rxd_i,
    output logic        txd_o,
    input  logic [15:0] core_a_i,
    input  logic [15:0] core_dout_i,
    input  logic        core_wr_i,
    input  logic        core_rd_i,
    input  logic [1:0]  core_be_i,
    output logic        core_stall_o,
    output logic        core_hold_o,
    output logic        core_start_o,
    output logic [15:0] start_addr_o,
    output logic [15:0] mem_a_o,
    output logic [15:0] mem_dout_o,
    output logic        mem_wr_o,
    output logic        mem_rd_o,
    output logic [1:0]  mem_be_o,
    output logic        rx_err_o
);

    localparam int TW = $clog2(BIT_CLKS);
    localparam logic [TW-1:0] HALF_TIMER = TW'(BIT_CLKS / 2 - 1);
    localparam logic [TW-1:0] FULL_TIMER = TW'(BIT_CLKS - 1);

    localparam logic [2:0] ST_CMD  = 3'd0;
    localparam logic [2:0] ST_AHI  = 3'd1;
    localparam logic [2:0] ST_ALO  = 3'd2;
    localparam logic [2:0] ST_CNT  = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;
    localparam logic [2:0] ST_WR   = 3'd5;

    logic          rxMeta_q, rxSync_q, rxPrev_q;
    logic          rxBusy_q;
    logic [TW-1:0] rxTimer_q;
    logic [3:0]    rxBitCnt_q;
    logic [7:0]    rxShift_q;
    logic          rxValid_q;
    logic [7:0]    rxData_q;
    logic          rxFrameErr_q;

    // Bit counter 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rxMeta_q     <= 1'b1;
            rxSync_q     <= 1'b1;
            rxPrev_q     <= 1'b1;
            rxBusy_q     <= 1'b0;
            rxTimer_q    <= '0;
            rxBitCnt_q   <= '0;
            rxShift_q    <= '0;
            rxValid_q    <= 1'b0;
            rxData_q     <= '0;
            rxFrameErr_q <= 1'b0;
        end else begin
            rxMeta_q     <= rxd_i;
            rxSync_q     <= rxMeta_q;
            rxPrev_q     <= rxSync_q;
            rxValid_q    <= 1'b0;
            rxFrameErr_q <= 1'b0;
            if (!rxBusy_q) begin
                if (rxPrev_q && !rxSync_q) begin
                    rxBusy_q   <= 1'b1;
                    rxTimer_q  <= HALF_TIMER;
                    rxBitCnt_q <= '0;
                end
            end else if (rxTimer_q != '0) begin
                rxTimer_q <= rxTimer_q - 1'b1;
            end else begin
                rxTimer_q <= FULL_TIMER;
                case (rxBitCnt_q)
                    4'd0: begin
                        if (rxSync_q) rxBusy_q <= 1'b0;
                        else          rxBitCnt_q <= 4'd1;
                    end
                    4'd9: begin
                        rxBusy_q <= 1'b0;
                        if (rxSync_q) begin
                            rxValid_q <= 1'b1;
                            rxData_q  <= rxShift_q;
                        end else begin
                            rxFrameErr_q <= 1'b1;
                        end
                    end
                    default: begin
                        rxShift_q  <= {rxSync_q, rxShift_q[7:1]};
                        rxBitCnt_q <= rxBitCnt_q + 1'b1;
                    end
                endcase
            end
        end
    end

    logic [2:0]  st_q, st_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  wrByte_q, wrByte_d;
    logic        isStart_q, isStart_d;
    logic        hold_q, hold_d;
    logic        start_q, start_d;
    logic [15:0] startAddr_q, startAddr_d;
    logic        rxErr_q, rxErr_d;

    always_comb begin
        st_d        = st_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wrByte_d    = wrByte_q;
        isStart_d   = isStart_q;
        hold_d      = hold_q;
        start_d     = 1'b0;
        startAddr_d = startAddr_q;
        rxErr_d     = rxErr_q;
        if (rxFrameErr_q) begin
            rxErr_d = 1'b1;
            st_d    = ST_CMD;
        end else begin
            case (st_q)
                ST_CMD: begin
                    if (rxValid_q && rxData_q == 8'h30) begin
                        hold_d    = 1'b1;
                        isStart_d = 1'b0;
                        rxErr_d   = 1'b0;
                        st_d      = ST_AHI;
                    end else if (rxValid_q && rxData_q == 8'h31) begin
                        isStart_d = 1'b1;
                        st_d      = ST_AHI;
                    end
                end
                ST_AHI: begin
                    if (rxValid_q) begin
                        addr_d[15:8] = rxData_q;
                        st_d         = ST_ALO;
                    end
                end
                ST_ALO: begin
                    if (rxValid_q) begin
                        addr_d[7:0] = rxData_q;
                        st_d        = ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (rxValid_q) begin
                        if (isStart_q) begin
                            start_d     = 1'b1;
                            startAddr_d = addr_q;
                            hold_d      = 1'b0;
                            st_d        = ST_CMD;
                        end else if (rxData_q == 8'h00) begin
                            st_d = ST_CMD;
                        end else begin
                            cnt_d = rxData_q;
                            st_d  = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rxValid_q) begin
                        wrByte_d = rxData_q;
                        st_d     = ST_WR;
                    end
                end
                ST_WR: begin
                    addr_d = addr_q + 16'd1;
                    cnt_d  = cnt_q - 8'd1;
                    st_d   = (cnt_q == 8'd1) ? ST_CMD : ST_DATA;
                end
                default: st_d = ST_CMD;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            st_q        <= ST_CMD;
            addr_q      <= '0;
            cnt_q       <= '0;
            wrByte_q    <= '0;
            isStart_q   <= 1'b0;
            hold_q      <= 1'b0;
            start_q     <= 1'b0;
            startAddr_q <= '0;
            rxErr_q     <= 1'b0;
        end else begin
            st_q        <= st_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wrByte_q    <= wrByte_d;
            isStart_q   <= isStart_d;
            hold_q      <= hold_d;
            start_q     <= start_d;
            startAddr_q <= startAddr_d;
            rxErr_q     <= rxErr_d;
        end
    end

    // The loader owns the SRAM bus only during the single WR clock.
    logic loaderOwns;
    assign loaderOwns   = (st_q == ST_WR);
    assign core_stall_o = loaderOwns;
    assign core_hold_o  = hold_q;
    assign core_start_o = start_q;
    assign start_addr_o = startAddr_q;
    assign rx_err_o     = rxErr_q;
    assign mem_a_o      = loaderOwns ? addr_q : core_a_i;
    assign mem_dout_o   = loaderOwns ? {wrByte_q, wrByte_q} : core_dout_i;
    assign mem_wr_o     = loaderOwns ? 1'b1 : core_wr_i;
    assign mem_rd_o     = loaderOwns ? 1'b0 : core_rd_i;
    assign mem_be_o     = loaderOwns ? (addr_q[0] ? 2'b01 : 2'b10) : core_be_i;

`ifdef B16_LOADER_ECHO_EN
    logic          txd_q;
    logic          txBusy_q;
    logic [8:0]    txShift_q;
    logic [3:0]    txBitCnt_q;
    logic [TW-1:0] txTimer_q;

    // A byte arriving while the previous echo is still going out is not echoed.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            txd_q      <= 1'b1;
            txBusy_q   <= 1'b0;
            txShift_q  <= '1;
            txBitCnt_q <= '0;
            txTimer_q  <= '0;
        end else if (!txBusy_q) begin
            if (rxValid_q) begin
                txd_q      <= 1'b0;
                txBusy_q   <= 1'b1;
                txShift_q  <= {1'b1, rxData_q};
                txBitCnt_q <= 4'd9;
                txTimer_q  <= FULL_TIMER;
            end
        end else if (txTimer_q != '0) begin
            txTimer_q <= txTimer_q - 1'b1;
        end else if (txBitCnt_q == 4'd0) begin
            txBusy_q <= 1'b0;
        end else begin
            txd_q      <= txShift_q[0];
            txShift_q  <= {1'b1, txShift_q[8:1]};
            txBitCnt_q <= txBitCnt_q - 1'b1;
            txTimer_q  <= FULL_TIMER;
        end
    end

    assign txd_o = txd_q;
`else
    assign txd_o = 1'b1;
`endif

endmodule

// File: doc/b16_loader.md
# b16_loader

Serial download controller and memory-bus arbiter for the b16 eval board. Receives 8N1 bytes on the bit-bang input line, decodes a small command protocol and writes downloaded bytes into external SRAM. While it writes, it steals the SRAM bus from the b16 core. It can hold the core and restart it at a given address, and sits between the core's memory port and the board pins (a, d, wr_b, rd_b, ble_b, bhe_b).

## Interface
- BIT_CLKS, 87, clocks per serial bit (8700 ns at a 100 ns clk)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- rxd  in  1  serial input (din[0]), idle high
- txd  out  1  echo output, idle high
- core_a  in  16  core byte address
- core_dout  in  16  core write data
- core_wr, core_rd  in  1  core strobes, active-high
- core_be  in  2  core byte enables, [1]=high byte
- core_stall  out  1  core must repeat the current access
- core_hold  out  1  core frozen
- core_start  out  1  one-cycle restart pulse
- start_addr  out  16  restart address, valid with core_start
- mem_a  out  16  SRAM byte address
- mem_dout  out  16  SRAM write data
- mem_wr, mem_rd  out  1  SRAM strobes, active-high
- mem_be  out  2  SRAM byte enables
- rx_err  out  1  sticky framing-error flag, cleared by the next valid 0x30

## Operation
- **Receiver**
  - Two-flop synchroniser on rxd.
  - A falling edge starts a bit timer; the line is sampled at BIT_CLKS/2 and then every BIT_CLKS.
  - The start sample must be 0, otherwise return to idle (glitch).
  - Data is LSB first. A stop sample of 0 is a framing error: set rx_err, drop the byte, force the protocol FSM to CMD.
- **Protocol FSM** (CMD, AHI, ALO, CNT, DATA, WR)
  - CMD: 0x30 → core_hold=1, go to AHI. 0x31 → AHI. Any other byte is ignored.
  - AHI, ALO: load addr[15:8], then addr[7:0].
  - CNT: load cnt (8 bit).
    - For 0x30 with cnt=0 → CMD, no writes.
    - For 0x31 the count byte is discarded; pulse core_start with start_addr=addr, clear core_hold, go to CMD.
  - DATA: on a byte, latch it, go to WR.
  - WR: one bus cycle. Then addr+1 (wraps 0xFFFF→0x0000) and cnt−1. If cnt reaches 0 → CMD (core_hold stays 1), else → DATA.
- **Byte lanes** (big-endian): even address → mem_be=2'b10; odd address → 2'b01. mem_dout={byte,byte}.
- **Arbitration**
  - In WR the loader owns the bus: mem_* are driven from the loader, mem_rd=0, core_stall=1.
  - Otherwise mem_* = core_* combinationally, core_stall=0.
  - The loader always wins; the core retries the next cycle.
- A 0x31 received while core_hold=0 still pulses core_start (soft restart).

## Timing
- **Reset values:** txd=1, core_stall=0, core_hold=0, core_start=0, start_addr=0, rx_err=0, FSM=CMD. mem_wr/mem_rd/mem_a/mem_be/mem_dout follow the core (loader idle).
- **Byte latency:** a byte is valid one clk after the mid-stop-bit sample. Entry to WR is on the next clk, and WR lasts exactly 1 clk.
- **core_hold** rises the clk after the 0x30 byte is valid.
- **core_start** is high for 1 clk, the clk after the 0x31 count byte is valid. core_hold falls in the same clk.
- **Reset mid-operation:** everything returns to its reset value immediately, and a partial download is abandoned. SRAM contents are not restored.
- Back-to-back bytes with zero idle between stop and start are accepted.

## Configuration
- **B16_LOADER_ECHO_EN defined:** an 8N1 transmitter at BIT_CLKS retransmits every valid received byte on txd, starting the clk after the byte is valid. If the transmitter is still busy, the echo of that byte is skipped; protocol handling is unaffected.
- **Not defined:** txd is constantly 1 and no transmitter logic exists.

## Test plan
- Send 0x30,03,02,04,12,34,56,78 → four single-cycle mem_wr:
  - a=0x0302, be=10, dout=0x1212
  - a=0x0303, be=01, dout=0x3434
  - a=0x0304, be=10, dout=0x5656
  - a=0x0305, be=01, dout=0x7878
  - core_hold=1 throughout, core_stall=1 exactly during those 4 clks.
- Then send 0x31,03,02,04 → core_start pulses 1 clk with start_addr=0x0302, core_hold→0, no mem_wr.
- Send 0x30,FF,FF,02,AA,BB → writes at 0xFFFF (be=01), then 0x0000 (be=10).
- Stop bit forced 0 on the 0x02 byte of a 0x30 header → rx_err=1, no writes. A following correct 0x30 header clears rx_err.
- Core asserts core_wr continuously during a download → core_stall high only in WR clks. Core write data appears on mem_* in all other clks.
- With B16_LOADER_ECHO_EN, send 0x5A → txd reproduces 0,0,1,0,1,1,0,1,0,1 at 87-clk spacing. Without the macro, txd stays 1.
